// File: rtl/apb_reg_pkg.sv
// Shared definitions for the APB register bridge: FSM states, the register
// address map and the per-address access permissions.
package apb_reg_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ACC  = 3'd1,
    RD_WAIT = 3'd2,
    RD_ACC  = 3'd3,
    ERR_ACC = 3'd4
  } state_e;

  localparam int REG_A_ADDR = 5;
  localparam int REG_B_ADDR = 10;
  localparam int REG_C_ADDR = 15;
  localparam int REG_D_ADDR = 20;

  typedef enum logic [1:0] {
    PERM_NONE = 2'd0,
    PERM_RW   = 2'd1,
    PERM_WO   = 2'd2,
    PERM_RO   = 2'd3
  } perm_e;

  // Unmapped addresses get PERM_NONE, which no access direction satisfies.
  function automatic logic perm_allows(input perm_e perm, input logic write);
    logic ok;
    ok = 1'b0;
    case (perm)
      PERM_RW: ok = 1'b1;
      PERM_WO: ok = write;
      PERM_RO: ok = !write;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational address/permission check for the four-entry register map.
// Kept standalone so other APB slaves can share the same map.
module apb_addr_decode
  import apb_reg_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] PADDR,
  input  logic              PWRITE,
  output logic              legal
);

  localparam logic [ADDR_W-1:0] ADDR_A = ADDR_W'(REG_A_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_B = ADDR_W'(REG_B_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_C = ADDR_W'(REG_C_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_D = ADDR_W'(REG_D_ADDR);

  perm_e perm;

  always_comb begin
    perm = PERM_NONE;
    if (PADDR == ADDR_A)      perm = PERM_RW;
    else if (PADDR == ADDR_B) perm = PERM_RW;
    else if (PADDR == ADDR_C) perm = PERM_WO;
    else if (PADDR == ADDR_D) perm = PERM_RO;
  end

  assign legal = perm_allows(perm, PWRITE);

endmodule

// File: rtl/apb_reg_bridge.sv
// APB3 slave front-end: turns APB transfers into single-cycle register
// strobes, flags illegal accesses with PSLVERR, and adds one read wait state.
module apb_reg_bridge
  import apb_reg_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic              reg_wr_en,
  output logic              reg_rd_en,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  input  logic [DATA_W-1:0] reg_rdata
);

  // Handshake: a transfer starts with a setup cycle (PSEL=1, PENABLE=0) seen
  // in IDLE and completes in the first access cycle where PREADY=1; PSLVERR
  // and PRDATA are meaningful only in that cycle. Dropping PSEL mid-transfer
  // abandons it without completion.
  state_e state_q;
  state_e state_d;
  logic   legal;
  logic   setup;

  apb_addr_decode #(
    .ADDR_W(ADDR_W)
  ) u_addr_decode (
    .PADDR (PADDR),
    .PWRITE(PWRITE),
    .legal (legal)
  );

  assign setup = PSEL && !PENABLE;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      reg_addr  <= '0;
      reg_wdata <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && setup) begin
        reg_addr  <= PADDR;
        reg_wdata <= PWDATA;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (setup) begin
          if (!legal)      state_d = ERR_ACC;
          else if (PWRITE) state_d = WR_ACC;
          else             state_d = RD_WAIT;
        end
      end
      RD_WAIT: state_d = PSEL ? RD_ACC : IDLE;
      WR_ACC:  state_d = IDLE;
      RD_ACC:  state_d = IDLE;
      ERR_ACC: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes live in the first cycle after setup, so each fires exactly once.
  always_comb begin
    reg_wr_en = 1'b0;
    reg_rd_en = 1'b0;
    PREADY    = 1'b0;
    PSLVERR   = 1'b0;
    PRDATA    = '0;
    case (state_q)
      WR_ACC: begin
        reg_wr_en = 1'b1;
        PREADY    = 1'b1;
      end
      RD_WAIT: reg_rd_en = 1'b1;
      RD_ACC: begin
        PREADY = 1'b1;
        PRDATA = reg_rdata;
      end
      ERR_ACC: begin
        PREADY  = 1'b1;
        PSLVERR = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_apb_reg_bridge.sv
// Directed bench for apb_reg_bridge with a behavioural register block,
// strobe/response scoreboards and a negedge monitor.
module tb_apb_reg_bridge;
  import apb_reg_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int SW = 2 + ADDR_W + DATA_W;
  localparam int RW = 1 + DATA_W;

  logic              clk;
  logic              rst_n;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;
  logic              reg_wr_en;
  logic              reg_rd_en;
  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_wdata;
  logic [DATA_W-1:0] reg_rdata;

  logic [SW-1:0] strb_q[$];
  logic [RW-1:0] exp_q[$];
  int compared;
  int mismatched;
  bit mon_en;

  apb_reg_bridge #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PADDR    (PADDR),
    .PWDATA   (PWDATA),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY),
    .PSLVERR  (PSLVERR),
    .reg_wr_en(reg_wr_en),
    .reg_rd_en(reg_rd_en),
    .reg_addr (reg_addr),
    .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- register block model ----------------
  logic [DATA_W-1:0] mem [0:31];
  initial reg_rdata = '0;
  always @(posedge clk) begin
    if (reg_wr_en) mem[reg_addr[4:0]] <= reg_wdata;
    if (reg_rd_en)
      reg_rdata <= (reg_addr == 32'd20) ? 32'd99 : mem[reg_addr[4:0]];
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input string what);
    compared++;
    mismatched++;
    $display("FAIL %s: %s", name, what);
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [SW-1:0] strb_exp;
  logic [RW-1:0] resp_exp;
  always @(negedge clk) begin
    if (mon_en) begin
      if (reg_wr_en || reg_rd_en) begin
        if (strb_q.size() == 0) begin
          flag("unexpected_strobe", $sformatf("wr=%0b rd=%0b addr=%0d, none expected",
               reg_wr_en, reg_rd_en, reg_addr));
        end else begin
          strb_exp = strb_q.pop_front();
          check("strobe", {reg_wr_en, reg_rd_en, reg_addr, reg_wdata}, strb_exp);
        end
      end
      if (PSEL && PENABLE && PREADY) begin
        if (exp_q.size() == 0) begin
          flag("unexpected_response", $sformatf("slverr=%0b prdata=%0h, none expected",
               PSLVERR, PRDATA));
        end else begin
          resp_exp = exp_q.pop_front();
          check("response", {PSLVERR, PRDATA}, resp_exp);
        end
      end
      if (!PSEL) check("idle_outputs", {PREADY, PSLVERR, PRDATA}, '0);
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 after the completion edge.
  task automatic apb_xfer(input bit wr, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] data, input bit err,
                          input logic [DATA_W-1:0] exp_rdata);
    int waits;
    int exp_waits;
    if (!err) strb_q.push_back({wr, !wr, addr, data});
    exp_q.push_back({err, (err || wr) ? 32'd0 : exp_rdata});
    exp_waits = (!err && !wr) ? 1 : 0;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    waits = 0;
    forever begin
      @(negedge clk);
      if (PREADY) break;
      waits++;
      if (waits > 8) begin
        flag("pready_timeout", $sformatf("addr=%0d no PREADY after 8 cycles", addr));
        break;
      end
    end
    @(posedge clk); #1;
    check($sformatf("wait_states_addr%0d", addr), 128'(waits), 128'(exp_waits));
  endtask

  task automatic apb_idle(input int cycles);
    PSEL = 1'b0; PENABLE = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    compared = 0; mismatched = 0; mon_en = 1'b0;
    rst_n = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ctrl", {PREADY, PSLVERR, reg_wr_en, reg_rd_en}, 4'b0);
    check("reset_data", {PRDATA, reg_addr, reg_wdata}, '0);
    check("reset_state", 128'(dut.state_q), 128'(IDLE));
    rst_n = 1'b1;
    mon_en = 1'b1;
    apb_idle(1);

    apb_xfer(1'b1, 32'd5, 32'hDEADBEEF, 1'b0, 32'd0);
    apb_idle(1);
    apb_xfer(1'b0, 32'd5, 32'd0, 1'b0, 32'hDEADBEEF);
    apb_idle(1);

    apb_xfer(1'b0, 32'd15, 32'd0, 1'b1, 32'd0);
    apb_idle(1);
    apb_xfer(1'b1, 32'd20, 32'h5555AAAA, 1'b1, 32'd0);
    apb_idle(1);
    apb_xfer(1'b1, 32'd7, 32'h01020304, 1'b1, 32'd0);
    apb_xfer(1'b0, 32'd7, 32'd0, 1'b1, 32'd0);
    apb_idle(1);

    apb_xfer(1'b0, 32'd20, 32'd0, 1'b0, 32'd99);
    apb_idle(1);

    apb_xfer(1'b1, 32'd10, 32'h1234, 1'b0, 32'd0);
    apb_xfer(1'b0, 32'd10, 32'd0, 1'b0, 32'h1234);
    apb_xfer(1'b1, 32'd15, 32'h000000A5, 1'b0, 32'd0);
    apb_idle(1);

    // Access phase without a setup phase must be ignored.
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 32'd5; PWDATA = 32'hBAD0BAD0;
    repeat (2) @(posedge clk);
    #1;
    check("no_setup_state", 128'(dut.state_q), 128'(IDLE));
    apb_idle(1);

    // Abort a read in its wait state.
    strb_q.push_back({1'b0, 1'b1, 32'd10, 32'd0});
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'd10; PWDATA = 32'd0;
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge clk); #1;
    check("abort_state", 128'(dut.state_q), 128'(IDLE));
    apb_idle(2);

    // Reset while in the read wait state.
    strb_q.push_back({1'b0, 1'b1, 32'd5, 32'd0});
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'd5; PWDATA = 32'd0;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_ctrl", {PREADY, PSLVERR, reg_wr_en, reg_rd_en}, 4'b0);
    check("rst_mid_data", {PRDATA, reg_addr, reg_wdata}, '0);
    check("rst_mid_state", 128'(dut.state_q), 128'(IDLE));
    rst_n = 1'b1;
    apb_idle(2);

    apb_xfer(1'b0, 32'd5, 32'd0, 1'b0, 32'hDEADBEEF);
    apb_idle(3);

    check("strobes_left", 128'(strb_q.size()), 128'(0));
    check("responses_left", 128'(exp_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within 100000 time units");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/apb_reg_bridge.md
# apb_reg_bridge

APB3 slave front-end that converts PSEL/PENABLE/PWRITE transfers into single-cycle write/read strobes for the four-entry register block and returns PRDATA/PREADY/PSLVERR to the APB master. It sits between the APB master and the register block. It decodes the address map, rejects illegal accesses with PSLVERR, and inserts the one wait state needed to cover the register block's registered read data.

## Interface
Parameters:
- ADDR_W, 32, APB and register address width
- DATA_W, 32, APB and register data width

Ports:
- clk  in  1  single system clock; all logic on posedge
- rst_n  in  1  synchronous, active-low reset, sampled on posedge clk
- PSEL  in  1  APB slave select
- PENABLE  in  1  APB access phase
- PWRITE  in  1  1 = write, 0 = read
- PADDR  in  ADDR_W  APB address
- PWDATA  in  DATA_W  APB write data
- PRDATA  out  DATA_W  APB read data
- PREADY  out  1  transfer completes this cycle
- PSLVERR  out  1  error response, valid only while PREADY=1
- reg_wr_en  out  1  one-cycle write strobe to register block
- reg_rd_en  out  1  one-cycle read strobe to register block
- reg_addr  out  ADDR_W  registered address to register block
- reg_wdata  out  DATA_W  registered write data to register block
- reg_rdata  in  DATA_W  register block read data, valid one cycle after reg_rd_en

## Operation
- Address map: 5 = A (RW), 10 = B (RW), 15 = C (write-only), 20 = D (read-only).
- Illegal accesses:
  - any other address;
  - read of 15;
  - write of 20.
- Illegal accesses produce no strobe and complete with PSLVERR=1 and PRDATA=0.
- FSM states: IDLE, WR_ACC, RD_WAIT, RD_ACC, ERR_ACC.
- IDLE, on posedge with PSEL=1 and PENABLE=0 (setup phase):
  - latch PADDR into reg_addr and PWDATA into reg_wdata;
  - illegal access → ERR_ACC;
  - legal write → WR_ACC, with reg_wr_en=1 for exactly one cycle;
  - legal read → RD_WAIT, with reg_rd_en=1 for exactly one cycle.
- WR_ACC → IDLE. RD_WAIT → RD_ACC. RD_ACC → IDLE. ERR_ACC → IDLE.
- PSEL=1 with PENABLE=1 while in IDLE is a protocol violation: ignored, no strobe.
- PSEL=0 in any non-IDLE state aborts to IDLE next edge.
  - A write strobe already issued is not retracted.
  - No further strobes are issued.
- Outputs are Moore-decoded from state:
  - PREADY=1 in WR_ACC, RD_ACC, ERR_ACC; 0 in IDLE and RD_WAIT;
  - PSLVERR=1 only in ERR_ACC;
  - PRDATA = reg_rdata in RD_ACC, else 0.
- Reset (rst_n=0 at posedge), regardless of state: FSM to IDLE; reg_wr_en, reg_rd_en, PREADY, PSLVERR = 0; reg_addr, reg_wdata, PRDATA = 0.
- Reset mid-transfer drops the transfer with no completion.

## Timing
- Setup at cycle T. Write: reg_wr_en high during T+1 and PREADY high in T+1, so zero wait states. The register block updates at the end of T+1.
- Read: reg_rd_en high during T+1 with PREADY=0. reg_rdata is valid in T+2, where PREADY=1 and PRDATA is driven, so one wait state.
- Error: PREADY=1 and PSLVERR=1 in T+1, zero wait states.
- Back-to-back transfers: the next setup may arrive in the cycle after completion. IDLE accepts it, so there are no idle bubbles beyond APB's own.
- Maximum strobe rate is one per two cycles.
- reg_wr_en and reg_rd_en are never high together.

## Structure
- Shared package apb_reg_pkg holds:
  - FSM state enum;
  - address constants REG_A_ADDR=5, REG_B_ADDR=10, REG_C_ADDR=15, REG_D_ADDR=20;
  - access-permission constants (RW, WO, RO).
- Sub-module apb_addr_decode, purely combinational:
  - inputs: PADDR, PWRITE;
  - output: legal;
  - reused by future APB slaves.

## Test plan
- Write 0xDEADBEEF to 5: reg_wr_en pulses once in T+1 with reg_addr=5; PREADY=1 and PSLVERR=0 in T+1. A following read of 5 returns 0xDEADBEEF in T+2 with PREADY low in T+1.
- Read 15: no reg_rd_en; PREADY=1, PSLVERR=1, PRDATA=0 in T+1. Write 20 and access to 7: the same error response, no strobe.
- Read 20 after reset, with register D at 99: PRDATA=99 (0x63) in T+2, PSLVERR=0.
- Back-to-back write 10 ← 0x1234, then read 10 with setup immediately after completion: strobes never overlap, and the read returns 0x1234.
- Drop PSEL in RD_WAIT: FSM returns to IDLE, PREADY stays 0, no second strobe.
- Assert rst_n=0 in RD_WAIT: next cycle all outputs are 0 and the FSM is in IDLE.
